// File: rtl/scan_pixel_packer.sv
// scan_pixel_packer: packs eight 16-bit scan samples per 128-bit word into the front FIFO, holding one word across full stalls
module scan_pixel_packer #(
  parameter logic [15:0] PAD_VALUE = 16'h0000,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             pix_valid,
  input  logic [15:0]      pix_data,
  input  logic             pix_last,
  output logic [127:0]     data_front,
  output logic             wrreq_front,
  input  logic             wrfull_front,
  output logic             pix_drop,
  output logic [CNT_W-1:0] ovf_cnt,
  output logic [CNT_W-1:0] frame_cnt,
  output logic             busy
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state, state_nx;
  logic [2:0] idx;
  logic [15:0] lanes [8];
  logic [127:0] hold, word;
  logic hold_full, accept, complete, issue, hold_free;
  assign accept = en & pix_valid & (state != DRAIN);
  assign complete = (state == DRAIN) | (accept & (pix_last | idx == 3'd7));
  // writes are spaced by at least one idle cycle to protect the FIFO's last slot
  assign issue = hold_full & ~wrfull_front & ~wrreq_front;
  assign hold_free = ~hold_full | issue;
  assign busy = (idx != 3'd0) | hold_full | (state == DRAIN);
  for (genvar g = 0; g < 8; g++) begin : g_lane
    assign word[16*g +: 16] = 3'(g) < idx ? lanes[g] :
                              (3'(g) == idx && state != DRAIN) ? pix_data : PAD_VALUE;
  end
  always_comb begin
    state_nx = state;
    if (state == DRAIN) state_nx = IDLE;
    else if (en) state_nx = RUN;
    else state_nx = idx != 3'd0 ? DRAIN : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx <= '0;
      hold <= '0;
      hold_full <= 1'b0;
      data_front <= '0;
      wrreq_front <= 1'b0;
      pix_drop <= 1'b0;
      ovf_cnt <= '0;
      frame_cnt <= '0;
    end else begin
      state <= state_nx;
      wrreq_front <= issue;
      if (issue) data_front <= hold;
      pix_drop <= complete & ~hold_free;
      if (complete & ~hold_free & ~&ovf_cnt) ovf_cnt <= ovf_cnt + CNT_W'(1);
      if (accept & pix_last & ~&frame_cnt) frame_cnt <= frame_cnt + CNT_W'(1);
      if (accept) lanes[idx] <= pix_data;
      idx <= complete ? 3'd0 : accept ? idx + 3'd1 : idx;
      if (complete & hold_free) begin
        hold <= word;
        hold_full <= 1'b1;
      end else if (issue) hold_full <= 1'b0;
    end
  end
endmodule

// File: tb/tb_scan_pixel_packer.sv
// tb_scan_pixel_packer: directed and random stimulus checked against a queue-based model of the packer
module tb_scan_pixel_packer;
  logic clk = 1'b0;
  logic rst, en, pix_valid, pix_last, wrfull_front;
  logic [15:0] pix_data;
  logic [127:0] data_front;
  logic wrreq_front, pix_drop, busy;
  logic [15:0] ovf_cnt, frame_cnt;
  int n_chk = 0, n_fail = 0;
  logic [15:0] q[$];
  bit m_drain, m_held, m_wrreq, m_drop;
  logic [127:0] m_hword, m_data;
  int m_ovf, m_frame;
  always #5 clk = ~clk;
  scan_pixel_packer dut (
    .clk(clk), .rst(rst), .en(en), .pix_valid(pix_valid), .pix_data(pix_data),
    .pix_last(pix_last), .data_front(data_front), .wrreq_front(wrreq_front),
    .wrfull_front(wrfull_front), .pix_drop(pix_drop), .ovf_cnt(ovf_cnt),
    .frame_cnt(frame_cnt), .busy(busy)
  );
  function automatic logic [127:0] pack();
    logic [127:0] p;
    for (int i = 0; i < 8; i++) p[16*i +: 16] = i < q.size() ? q[i] : 16'h0000;
    return p;
  endfunction
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s at %0t: observed %h expected %h", tag, $time, obs, exp);
    end
  endtask
  task automatic model(input bit r, e, v, input logic [15:0] d, input bit l, f);
    bit have, iss;
    logic [127:0] w;
    if (r) begin
      q.delete();
      m_drain = 0; m_held = 0; m_wrreq = 0; m_drop = 0;
      m_hword = '0; m_data = '0; m_ovf = 0; m_frame = 0;
      return;
    end
    iss = m_held && !f && !m_wrreq;
    have = 0;
    w = '0;
    if (m_drain) begin
      w = pack(); q.delete(); have = 1; m_drain = 0;
    end else if (e && v) begin
      q.push_back(d);
      if (l && m_frame < 65535) m_frame++;
      if (l || q.size() == 8) begin w = pack(); q.delete(); have = 1; end
    end else if (!e && q.size() > 0) m_drain = 1;
    m_wrreq = iss;
    if (iss) m_data = m_hword;
    m_drop = have && m_held && !iss;
    if (have) begin
      if (!m_held || iss) begin m_hword = w; m_held = 1; end
      else if (m_ovf < 65535) m_ovf++;
    end else if (iss) m_held = 0;
  endtask
  task automatic step(input bit r, e, v, input logic [15:0] d, input bit l, f);
    rst = r; en = e; pix_valid = v; pix_data = d; pix_last = l; wrfull_front = f;
    @(posedge clk);
    model(r, e, v, d, l, f);
    #1;
    chk("wrreq", 128'(wrreq_front), 128'(m_wrreq));
    chk("data", data_front, m_data);
    chk("drop", 128'(pix_drop), 128'(m_drop));
    chk("ovf", 128'(ovf_cnt), 128'(m_ovf));
    chk("frame", 128'(frame_cnt), 128'(m_frame));
    chk("busy", 128'(busy), 128'(q.size() != 0 || m_held || m_drain));
  endtask
  initial begin
    int w;
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_data", data_front, 128'(0));
    // eight samples, FIFO ready
    step(0, 1, 0, 0, 0, 0);
    for (int i = 1; i <= 8; i++) step(0, 1, 1, 16'(i), 0, 0);
    step(0, 1, 0, 0, 0, 0);
    chk("t1_wrreq", 128'(wrreq_front), 128'(1));
    chk("t1_data", data_front, 128'h0008_0007_0006_0005_0004_0003_0002_0001);
    step(0, 1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    // short frame
    step(0, 1, 1, 16'hA0A0, 0, 0);
    step(0, 1, 1, 16'hB1B1, 0, 0);
    step(0, 1, 1, 16'hC2C2, 1, 0);
    step(0, 1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    chk("t2_data", data_front, {80'h0, 16'hC2C2, 16'hB1B1, 16'hA0A0});
    chk("t2_frame", 128'(frame_cnt), 128'(1));
    chk("t2_busy", 128'(busy), 128'(0));
    // stall with one word held
    for (int i = 0; i < 8; i++) step(0, 1, 1, 16'h3300 + 16'(i), 0, 1);
    for (int i = 0; i < 20; i++) step(0, 1, 0, 0, 0, 1);
    step(0, 1, 0, 0, 0, 0);
    chk("t3_wrreq", 128'(wrreq_front), 128'(1));
    chk("t3_data", data_front, 128'h3307_3306_3305_3304_3303_3302_3301_3300);
    step(0, 1, 0, 0, 0, 0);
    // overflow: two words dropped behind the held one
    for (int i = 0; i < 24; i++) step(0, 1, 1, 16'h4400 + 16'(i), 0, 1);
    chk("t4_ovf", 128'(ovf_cnt), 128'(2));
    w = 0;
    for (int i = 0; i < 6; i++) begin
      step(0, 1, 0, 0, 0, 0);
      if (wrreq_front) w++;
    end
    chk("t4_writes", 128'(w), 128'(1));
    chk("t4_data", data_front, 128'h4407_4406_4405_4404_4403_4402_4401_4400);
    // enable drop mid-word
    for (int i = 1; i <= 5; i++) step(0, 1, 1, 16'h5500 + 16'(i), 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0);
    chk("t5_data", data_front, {48'h0, 16'h5505, 16'h5504, 16'h5503, 16'h5502, 16'h5501});
    chk("t5_frame", 128'(frame_cnt), 128'(1));
    chk("t5_busy", 128'(busy), 128'(0));
    // reset with a held word and a partial word
    for (int i = 0; i < 11; i++) step(0, 1, 1, 16'h6600 + 16'(i), 0, 1);
    step(1, 1, 0, 0, 0, 0);
    chk("t6_busy", 128'(busy), 128'(0));
    chk("t6_wrreq", 128'(wrreq_front), 128'(0));
    chk("t6_ovf", 128'(ovf_cnt), 128'(0));
    step(0, 1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    chk("t6_idle_wrreq", 128'(wrreq_front), 128'(0));
    // random traffic with bursty FIFO-full
    begin
      bit f = 0;
      for (int i = 0; i < 4000; i++) begin
        if ($urandom_range(9) == 0) f = ~f;
        step($urandom_range(599) == 0, $urandom_range(15) != 0, $urandom_range(3) != 0,
             16'($urandom), $urandom_range(11) == 0, f);
      end
    end
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 0, 0);
    chk("final_busy", 128'(busy), 128'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
